// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - smartcard glitch sequencer: edge count, delay, pulse train
// Serial config link is synchronised into sc_clk; all state lives in the sc_clk domain.
module glitch_sequencer #(
  parameter int          CNT_W         = 32,
  parameter int          PW_W          = 16,
  parameter int          RPT_W         = 8,
  parameter bit          IO_EDGE_RISE  = 1'b1,
  parameter int unsigned DEF_IO_TARGET = 720,
  parameter int unsigned DEF_CLK_DELAY = 13255
) (
  input  logic             sc_clk,
  input  logic             sc_reset,
  input  logic             sc_io,
  input  logic             arm,
  input  logic             prog_clk,
  input  logic             prog_io,
  input  logic             prog_latch,
  output logic             trigger,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [RPT_W:0]   pulse_cnt
);

  localparam int PC_W = RPT_W + 1;
  localparam int SR_W = CNT_W + 3;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT_IO, S_DELAY, S_PULSE, S_GAP, S_DONE
  } state_t;

  logic [1:0] io_sync, pclk_sync, pio_sync, plat_sync;
  logic       io_prev, pclk_prev, plat_prev, io_strobe;
  logic       pclk_rise, plat_rise;

  always_ff @(posedge sc_clk or negedge sc_reset) begin
    if (!sc_reset) begin
      io_sync   <= '0;
      pclk_sync <= '0;
      pio_sync  <= '0;
      plat_sync <= '0;
      io_prev   <= 1'b0;
      pclk_prev <= 1'b0;
      plat_prev <= 1'b0;
      io_strobe <= 1'b0;
    end else begin
      io_sync   <= {io_sync[0], sc_io};
      pclk_sync <= {pclk_sync[0], prog_clk};
      pio_sync  <= {pio_sync[0], prog_io};
      plat_sync <= {plat_sync[0], prog_latch};
      io_prev   <= io_sync[1];
      pclk_prev <= pclk_sync[1];
      plat_prev <= plat_sync[1];
      io_strobe <= IO_EDGE_RISE ? (io_sync[1] & ~io_prev) : (~io_sync[1] & io_prev);
    end
  end

  assign pclk_rise = pclk_sync[1] & ~pclk_prev;
  assign plat_rise = plat_sync[1] & ~plat_prev;

  logic [SR_W-1:0]  shift_q;
  logic [CNT_W-1:0] io_target, clk_delay, repeat_gap;
  logic [PW_W-1:0]  pulse_width;
  logic [RPT_W-1:0] repeat_count;
  state_t           state_q, state_d;

  always_ff @(posedge sc_clk or negedge sc_reset) begin
    if (!sc_reset) begin
      shift_q <= '0;
    end else if (pclk_rise) begin
      shift_q <= {shift_q[SR_W-2:0], pio_sync[1]};
    end
  end

  // A frame landing mid-run is dropped so a live sequence never changes shape.
  always_ff @(posedge sc_clk or negedge sc_reset) begin
    if (!sc_reset) begin
      io_target    <= CNT_W'(DEF_IO_TARGET);
      clk_delay    <= CNT_W'(DEF_CLK_DELAY);
      pulse_width  <= PW_W'(1);
      repeat_count <= '0;
      repeat_gap   <= '0;
      cfg_err      <= 1'b0;
    end else if (plat_rise) begin
      if (busy) begin
        cfg_err <= 1'b1;
      end else begin
        case (shift_q[CNT_W+2:CNT_W])
          3'd0:    io_target    <= shift_q[CNT_W-1:0];
          3'd1:    clk_delay    <= shift_q[CNT_W-1:0];
          3'd2:    pulse_width  <= shift_q[PW_W-1:0];
          3'd3:    repeat_count <= shift_q[RPT_W-1:0];
          3'd4:    repeat_gap   <= shift_q[CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  logic [CNT_W-1:0] edge_cnt, edge_cnt_d, delay_cnt, delay_cnt_d, gap_cnt, gap_cnt_d;
  logic [PW_W-1:0]  pw_cnt, pw_cnt_d;
  logic [PC_W-1:0]  pulse_cnt_q, pulse_cnt_d, pulse_base, rpt_total;
  logic [CNT_W-1:0] edge_inc, gap_limit;
  logic [PW_W-1:0]  pw_limit;
  logic             delay_last, pw_last, gap_last, trigger_q;
  state_t           delay_entry;

  assign edge_inc    = (&edge_cnt) ? edge_cnt : edge_cnt + CNT_W'(1);
  assign pw_limit    = (pulse_width == '0) ? PW_W'(1) : pulse_width;
  assign gap_limit   = (repeat_gap == '0) ? CNT_W'(1) : repeat_gap;
  assign delay_last  = (clk_delay == '0) || (delay_cnt >= clk_delay - CNT_W'(1));
  assign pw_last     = pw_cnt >= pw_limit - PW_W'(1);
  assign gap_last    = gap_cnt >= gap_limit - CNT_W'(1);
  assign rpt_total   = {1'b0, repeat_count} + PC_W'(1);
  assign delay_entry = (clk_delay == '0) ? S_PULSE : S_DELAY;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign trigger     = trigger_q;
  assign pulse_cnt   = pulse_cnt_q;

  always_comb begin
    state_d     = state_q;
    edge_cnt_d  = edge_cnt;
    delay_cnt_d = delay_cnt;
    pw_cnt_d    = pw_cnt;
    gap_cnt_d   = gap_cnt;
    pulse_cnt_d = pulse_cnt_q;
    pulse_base  = pulse_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          edge_cnt_d  = '0;
          pulse_cnt_d = '0;
          pulse_base  = '0;
          delay_cnt_d = '0;
          state_d     = (io_target == '0) ? delay_entry : S_COUNT_IO;
        end
      end
      S_COUNT_IO: begin
        if (io_strobe) begin
          edge_cnt_d = edge_inc;
          if (edge_inc == io_target) begin
            delay_cnt_d = '0;
            state_d     = delay_entry;
          end
        end
      end
      S_DELAY: begin
        delay_cnt_d = (&delay_cnt) ? delay_cnt : delay_cnt + CNT_W'(1);
        if (delay_last) state_d = S_PULSE;
      end
      S_PULSE: begin
        pw_cnt_d = (&pw_cnt) ? pw_cnt : pw_cnt + PW_W'(1);
        if (pw_last) begin
          gap_cnt_d = '0;
          state_d   = (pulse_cnt_q == rpt_total) ? S_DONE : S_GAP;
        end
      end
      S_GAP: begin
        gap_cnt_d = (&gap_cnt) ? gap_cnt : gap_cnt + CNT_W'(1);
        if (gap_last) state_d = S_PULSE;
      end
      S_DONE: begin
        if (!arm) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!arm && busy) state_d = S_IDLE;
    // Pulse number advances on the same edge the pulse starts.
    if (state_d == S_PULSE && state_q != S_PULSE) begin
      pw_cnt_d    = '0;
      pulse_cnt_d = (&pulse_base) ? pulse_base : pulse_base + PC_W'(1);
    end
  end

  always_ff @(posedge sc_clk or negedge sc_reset) begin
    if (!sc_reset) begin
      state_q     <= S_IDLE;
      edge_cnt    <= '0;
      delay_cnt   <= '0;
      pw_cnt      <= '0;
      gap_cnt     <= '0;
      pulse_cnt_q <= '0;
      trigger_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_cnt    <= edge_cnt_d;
      delay_cnt   <= delay_cnt_d;
      pw_cnt      <= pw_cnt_d;
      gap_cnt     <= gap_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      trigger_q   <= (state_d == S_PULSE);
    end
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb/tb_glitch_sequencer.sv - scoreboard bench for glitch_sequencer
module tb_glitch_sequencer;

  logic       sc_clk = 1'b0, sc_reset = 1'b0, sc_io = 1'b0, sc_io_f = 1'b0;
  logic       arm = 1'b0, arm_f = 1'b0, prog_clk = 1'b0, prog_io = 1'b0, prog_latch = 1'b0;
  logic       trigger, busy, done, cfg_err, trigger_f, busy_f, done_f, cfg_err_f;
  logic [8:0] pulse_cnt, pulse_cnt_f;

  glitch_sequencer u_dut (
    .sc_clk(sc_clk), .sc_reset(sc_reset), .sc_io(sc_io), .arm(arm),
    .prog_clk(prog_clk), .prog_io(prog_io), .prog_latch(prog_latch),
    .trigger(trigger), .busy(busy), .done(done), .cfg_err(cfg_err), .pulse_cnt(pulse_cnt)
  );

  glitch_sequencer #(.IO_EDGE_RISE(1'b0)) u_dut_fall (
    .sc_clk(sc_clk), .sc_reset(sc_reset), .sc_io(sc_io_f), .arm(arm_f),
    .prog_clk(prog_clk), .prog_io(prog_io), .prog_latch(prog_latch),
    .trigger(trigger_f), .busy(busy_f), .done(done_f), .cfg_err(cfg_err_f), .pulse_cnt(pulse_cnt_f)
  );

  always #5 sc_clk = ~sc_clk;

  int cyc = 0;
  always @(posedge sc_clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;

  typedef struct { int rise; int width; int pcnt; } pulse_t;
  pulse_t exp_q0[$], exp_q1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  int   rise_c[2], wid[2], pc_at[2];
  logic prev_t[2] = '{1'b0, 1'b0};

  task automatic mon_step(input int id, input logic t, input logic [8:0] pc);
    pulse_t e;
    if (t && !prev_t[id]) begin
      rise_c[id] = cyc;
      wid[id]    = 0;
      pc_at[id]  = int'(pc);
    end
    if (t) wid[id]++;
    if (!t && prev_t[id]) begin
      if ((id == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse dut%0d: rise %0d width %0d, none expected", id, rise_c[id], wid[id]);
      end else begin
        e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("pulse_rise dut%0d", id), rise_c[id], e.rise);
        check($sformatf("pulse_width dut%0d", id), wid[id], e.width);
        check($sformatf("pulse_cnt dut%0d", id), pc_at[id], e.pcnt);
      end
    end
    prev_t[id] = t;
  endtask

  always @(negedge sc_clk) begin
    mon_step(0, trigger, pulse_cnt);
    mon_step(1, trigger_f, pulse_cnt_f);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sc_clk);
  endtask

  task automatic push(input int id, input int rise, input int width, input int pcnt);
    pulse_t e;
    e.rise = rise; e.width = width; e.pcnt = pcnt;
    if (id == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
  endtask

  task automatic prog_write(input logic [2:0] addr, input logic [31:0] data);
    logic [34:0] frame;
    frame = {addr, data};
    for (int i = 34; i >= 0; i--) begin
      prog_io = frame[i];
      tick(2); prog_clk = 1'b1;
      tick(3); prog_clk = 1'b0;
      tick(3);
    end
    prog_latch = 1'b1; tick(4);
    prog_latch = 1'b0; tick(4);
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && t < budget) begin
      tick(1);
      t++;
    end
    check("queue_drained", exp_q0.size() + exp_q1.size(), 0);
  endtask

  task automatic rise_edges(input int n, output int m);
    m = 0;
    for (int i = 0; i < n; i++) begin
      sc_io = 1'b1; m = cyc;
      tick(2);
      sc_io = 1'b0;
      tick(2);
    end
  endtask

  int m;

  initial begin
    tick(3);
    check("rst_trigger", trigger, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_pulse_cnt", pulse_cnt, 0);
    sc_reset = 1'b1;
    tick(2);

    // Three-pulse train: width 3, gap 4, delay 5, no edge wait.
    prog_write(3'd0, 0); prog_write(3'd1, 5); prog_write(3'd2, 3);
    prog_write(3'd3, 2); prog_write(3'd4, 4);
    m = cyc; arm = 1'b1;
    push(0, m + 6, 3, 1); push(0, m + 13, 3, 2); push(0, m + 20, 3, 3);
    wait_drain(100);
    tick(2);
    check("train_done", done, 1);
    check("train_pulse_cnt", pulse_cnt, 3);
    check("train_busy", busy, 0);
    arm = 1'b0; tick(2);
    check("disarm_done", done, 0);

    // Commit while busy is dropped; address 6 is ignored silently.
    prog_write(3'd0, 1000);
    arm = 1'b1; tick(3);
    check("busy_count_io", busy, 1);
    prog_write(3'd1, 50);
    check("cfg_err_set", cfg_err, 1);
    arm = 1'b0; tick(2);
    check("busy_after_disarm", busy, 0);
    prog_write(3'd0, 0);
    prog_write(3'd6, 0);
    check("cfg_err_sticky", cfg_err, 1);
    m = cyc; arm = 1'b1;
    push(0, m + 6, 3, 1); push(0, m + 13, 3, 2); push(0, m + 20, 3, 3);
    wait_drain(100);
    arm = 1'b0; tick(2);

    // Disarm mid-pulse truncates it.
    prog_write(3'd2, 20); prog_write(3'd3, 0);
    m = cyc; arm = 1'b1;
    push(0, m + 6, 3, 1);
    tick(8); arm = 1'b0;
    tick(2);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_trigger", trigger, 0);
    check("abort_pulse_cnt_hold", pulse_cnt, 1);
    wait_drain(20);

    // All-ones target never reached by three edges; width 0 acts as 1.
    prog_write(3'd0, 32'hFFFF_FFFF); prog_write(3'd1, 2); prog_write(3'd2, 0);
    arm = 1'b1; tick(2);
    rise_edges(3, m);
    tick(10);
    check("maxtgt_busy", busy, 1);
    check("maxtgt_pulse_cnt", pulse_cnt, 0);
    check("maxtgt_trigger", trigger, 0);
    arm = 1'b0; tick(2);
    prog_write(3'd0, 0);
    m = cyc; arm = 1'b1;
    push(0, m + 3, 1, 1);
    wait_drain(50);
    check("w0_done", done, 1);
    arm = 1'b0; tick(2);

    // Falling-edge build counts only falling sc_io transitions.
    prog_write(3'd0, 2); prog_write(3'd1, 3); prog_write(3'd2, 1);
    arm_f = 1'b1; tick(2);
    sc_io_f = 1'b1; tick(3);
    sc_io_f = 1'b0; tick(3);
    sc_io_f = 1'b1; tick(3);
    sc_io_f = 1'b0; m = cyc;
    push(1, m + 7, 1, 1);
    wait_drain(100);
    tick(2);
    check("fall_done", done_f, 1);
    arm_f = 1'b0; tick(2);

    // Reset in DELAY clears everything at once.
    prog_write(3'd1, 100);
    arm = 1'b1; tick(10);
    check("delay_busy", busy, 1);
    sc_reset = 1'b0; #1;
    check("async_rst_trigger", trigger, 0);
    check("async_rst_busy", busy, 0);
    tick(1);
    check("async_rst_cfg_err", cfg_err, 0);
    check("async_rst_pulse_cnt", pulse_cnt, 0);
    arm = 1'b0; sc_reset = 1'b1; tick(2);

    // Defaults: 720 rising edges then 13255-cycle delay.
    arm = 1'b1; tick(2);
    rise_edges(720, m);
    push(0, m + 4 + 13255, 1, 1);
    wait_drain(14000);
    tick(2);
    check("dflt_done", done, 1);
    check("dflt_pulse_cnt", pulse_cnt, 1);
    arm = 1'b0; tick(2);

    check("final_queue_empty", exp_q0.size() + exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
- Parametrised successor to the single-shot smartcard glitch trigger.
- Counts configurable-polarity edges on sc_io, waits a programmable number of sc_clk cycles, then emits a train of 1..2^RPT_W glitch pulses with programmable width and gap.
- Configuration arrives over the existing bit-serial prog_clk/prog_io/prog_latch link, synchronised into sc_clk; everything runs on the single sc_clk domain.
- Sits between the card interface pins and the glitch driver.

Parameters:
- CNT_W, 32, width of the edge-target, delay and gap registers and counters.
- PW_W, 16, width of the pulse-width register.
- RPT_W, 8, width of the repeat-count register.
- IO_EDGE_RISE, 1, 1 counts rising sc_io edges; 0 counts falling edges.
- DEF_IO_TARGET, 720, reset value of IO_EDGE_TARGET.
- DEF_CLK_DELAY, 13255, reset value of CLK_DELAY.

Ports:
- sc_clk, in, 1, card clock; sole clock.
- sc_reset, in, 1, asynchronous active-low reset.
- sc_io, in, 1, card I/O line (async, synchronised internally).
- arm, in, 1, level; high arms the sequencer.
- prog_clk, in, 1, serial config clock (async, max sc_clk/4).
- prog_io, in, 1, serial config data.
- prog_latch, in, 1, rising edge commits the shifted frame.
- trigger, out, 1, registered glitch pulse.
- busy, out, 1, high in any state except IDLE and DONE.
- done, out, 1, high in DONE.
- cfg_err, out, 1, sticky; frame committed while busy.
- pulse_cnt, out, RPT_W+1, pulses emitted this run.

Behaviour:
- Reset (async, sc_reset=0): state IDLE; trigger, done and cfg_err = 0; pulse_cnt = 0; all counters = 0; IO_EDGE_TARGET = DEF_IO_TARGET; CLK_DELAY = DEF_CLK_DELAY; PULSE_WIDTH = 1; REPEAT_COUNT = 0; REPEAT_GAP = 0. Reset mid-run aborts immediately and trigger drops asynchronously.
- Synchronisers: sc_io, prog_clk, prog_io and prog_latch each pass through 2 flops.
- Edge strobe: pulses for 1 cycle, 2 cycles after the first sc_clk edge that samples the new sc_io level.
- Serial config:
  - Shift register is 3+CNT_W bits wide. On each synced prog_clk rising edge it shifts left and loads synced prog_io into the LSB, so data is sent MSB-first.
  - On synced prog_latch rising edge, bits [CNT_W+2:CNT_W] are the address and [CNT_W-1:0] the data, truncated to the register width.
  - Address map: 0 = IO_EDGE_TARGET, 1 = CLK_DELAY, 2 = PULSE_WIDTH, 3 = REPEAT_COUNT, 4 = REPEAT_GAP. Addresses 5-7 are ignored with no error.
  - Commit while busy=1: dropped, cfg_err set. cfg_err clears only on reset.
  - The shift register is not cleared by a commit; extra bits shift older ones out.
- FSM states: IDLE, COUNT_IO, DELAY, PULSE, GAP, DONE.
  - IDLE: when arm=1, clear the edge counter and pulse_cnt. If IO_EDGE_TARGET = 0, go to DELAY; otherwise go to COUNT_IO.
  - COUNT_IO: increment the edge counter on each strobe. On the strobe that makes count == IO_EDGE_TARGET (cycle E), go to DELAY with the delay counter = 0.
  - DELAY: stay CLK_DELAY cycles, then go to PULSE. First trigger-high cycle is E+1+CLK_DELAY.
  - PULSE: trigger=1 for max(PULSE_WIDTH,1) cycles. pulse_cnt increments on the cycle PULSE is entered. Then, if pulse_cnt == REPEAT_COUNT+1, go to DONE; otherwise go to GAP.
  - GAP: trigger=0 for max(REPEAT_GAP,1) cycles, then go to PULSE.
  - DONE: done=1, trigger=0. Return to IDLE when arm=0.
  - arm=0 in any busy state: go to IDLE next cycle with trigger=0. pulse_cnt holds its value.
- Edge strobes outside COUNT_IO are ignored.
- Counters saturate, never wrap. A target of all-ones is reachable.
- Total pulses per run = REPEAT_COUNT+1 (REPEAT_COUNT all-ones gives 2^RPT_W pulses, so pulse_cnt is RPT_W+1 bits).
- trigger is driven from a flop, glitch-free.

Test Plan:
- Defaults after reset; arm=1; 720 rising sc_io edges -> trigger high exactly 13256 cycles after the 720th strobe, width 1; done=1; pulse_cnt=1.
- Program IO_EDGE_TARGET=0, CLK_DELAY=5, PULSE_WIDTH=3, REPEAT_COUNT=2, REPEAT_GAP=4; arm -> trigger pattern 3 high / 4 low / 3 high / 4 low / 3 high starting at cycle 6 after arm registers; pulse_cnt=3.
- IO_EDGE_RISE=0 build, target 2, toggle sc_io -> only falling edges are counted; firing follows the second falling edge.
- Serial frame committed while busy -> registers unchanged, cfg_err=1 and held. Frame to address 6 -> no change, cfg_err unchanged.
- arm dropped during PULSE -> trigger low next cycle, state IDLE. sc_reset asserted during DELAY -> trigger=0 immediately and defaults restored.
- IO_EDGE_TARGET = 2^CNT_W-1 with 3 edges, and PULSE_WIDTH=0 -> no fire, no counter wrap; width 0 yields a 1-cycle pulse.
